// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared definitions for the two-way Wishbone arbiter: FSM
//                state encoding, default timeout read data and small helpers.
//                The optional bus timeout is enabled with WB_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    // Arbiter state encoding (two bits, three legal states)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;

    // last_grant encoding: which master was granted most recently
    localparam logic C_LAST_A = 1'b0;
    localparam logic C_LAST_B = 1'b1;

    // Read data handed back when the arbiter fabricates an ack
    localparam logic [31:0] C_TIMEOUT_DATA_DEFAULT = 32'hDEAD_DEAD;

    // Width of the timeout counter
    localparam int C_TIMEOUT_CNT_W = 16;

    // A master is requesting when both cycle and strobe are asserted
    function automatic logic wb_req(input logic cyc, input logic stb);
        return cyc & stb;
    endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_timeout
//  Description : Wait-state counter for the arbiter bus timeout. Counts
//                granted strobe cycles without an ack and flags expiry when
//                the count equals TIMEOUT_CYCLES. Only instantiated when
//                WB_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_expired
);

    localparam logic [C_TIMEOUT_CNT_W-1:0] c_LIMIT = C_TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

    logic [C_TIMEOUT_CNT_W-1:0] r_count;

    // Count stalled strobe cycles; clear takes priority over counting
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_LIMIT);

endmodule : wb_arb_timeout
`default_nettype wire

// File: rtl/wb_arbiter_2way.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_2way
//  Description : Two-master to one-slave Wishbone arbiter. Round-robin on
//                simultaneous requests, grant held for the whole cycle (cyc)
//                of the winning master. Define WB_ARB_TIMEOUT_EN to build a
//                wait-state timeout that fabricates an ack with TIMEOUT_DATA.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_2way
    import wb_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = C_TIMEOUT_DATA_DEFAULT
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    // Upstream master A
    input  logic                  wbs_a_stb_i,
    input  logic                  wbs_a_cyc_i,
    input  logic                  wbs_a_we_i,
    input  logic [3:0]            wbs_a_sel_i,
    input  logic [31:0]           wbs_a_dat_i,
    input  logic [ADDR_WIDTH-1:0] wbs_a_adr_i,
    output logic                  wbs_a_ack_o,
    output logic [31:0]           wbs_a_dat_o,
    // Upstream master B
    input  logic                  wbs_b_stb_i,
    input  logic                  wbs_b_cyc_i,
    input  logic                  wbs_b_we_i,
    input  logic [3:0]            wbs_b_sel_i,
    input  logic [31:0]           wbs_b_dat_i,
    input  logic [ADDR_WIDTH-1:0] wbs_b_adr_i,
    output logic                  wbs_b_ack_o,
    output logic [31:0]           wbs_b_dat_o,
    // Downstream slave port
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_dat_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;
    logic       w_next_last_grant;

    logic       w_req_a;
    logic       w_req_b;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_granted;
    logic       w_timeout;

    // Muxed view of whichever master currently owns the bus
    logic                  w_sel_cyc;
    logic                  w_sel_stb;
    logic                  w_sel_we;
    logic [3:0]            w_sel_sel;
    logic [31:0]           w_sel_dat;
    logic [ADDR_WIDTH-1:0] w_sel_adr;
    logic                  w_up_ack;
    logic [31:0]           w_up_dat;

    assign w_req_a = wb_req(wbs_a_cyc_i, wbs_a_stb_i);
    assign w_req_b = wb_req(wbs_b_cyc_i, wbs_b_stb_i);

    // Reset gates the grant immediately so nothing leaks out during reset
    assign w_gnt_a   = (r_state == ST_GNT_A) && !wb_rst_i;
    assign w_gnt_b   = (r_state == ST_GNT_B) && !wb_rst_i;
    assign w_granted = w_gnt_a || w_gnt_b;

    // Next-state and round-robin bookkeeping
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_req_a && w_req_b) begin
                    if (r_last_grant == C_LAST_B) begin
                        w_next_state      = ST_GNT_A;
                        w_next_last_grant = C_LAST_A;
                    end else begin
                        w_next_state      = ST_GNT_B;
                        w_next_last_grant = C_LAST_B;
                    end
                end else if (w_req_a) begin
                    w_next_state      = ST_GNT_A;
                    w_next_last_grant = C_LAST_A;
                end else if (w_req_b) begin
                    w_next_state      = ST_GNT_B;
                    w_next_last_grant = C_LAST_B;
                end
            end
            ST_GNT_A: begin
                if (!wbs_a_cyc_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GNT_B: begin
                if (!wbs_b_cyc_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State and last-grant registers; reset makes A win the first tie
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= C_LAST_B;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Select the granted master's request signals
    always_comb begin
        w_sel_cyc = 1'b0;
        w_sel_stb = 1'b0;
        w_sel_we  = 1'b0;
        w_sel_sel = '0;
        w_sel_dat = '0;
        w_sel_adr = '0;
        if (w_gnt_a) begin
            w_sel_cyc = wbs_a_cyc_i;
            w_sel_stb = wbs_a_stb_i & wbs_a_cyc_i;
            w_sel_we  = wbs_a_we_i;
            w_sel_sel = wbs_a_sel_i;
            w_sel_dat = wbs_a_dat_i;
            w_sel_adr = wbs_a_adr_i;
        end else if (w_gnt_b) begin
            w_sel_cyc = wbs_b_cyc_i;
            w_sel_stb = wbs_b_stb_i & wbs_b_cyc_i;
            w_sel_we  = wbs_b_we_i;
            w_sel_sel = wbs_b_sel_i;
            w_sel_dat = wbs_b_dat_i;
            w_sel_adr = wbs_b_adr_i;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic w_cnt_en;
    logic w_cnt_clr;
    logic w_expired;

    // Count only genuine wait states; any ack, expiry or loss of grant restarts
    assign w_cnt_en  = w_granted && w_sel_stb && !wbm_ack_i && !w_timeout;
    assign w_cnt_clr = !w_granted || wbm_ack_i || w_timeout;
    assign w_timeout = w_granted && w_expired;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_count_en (w_cnt_en),
        .i_clear    (w_cnt_clr),
        .o_expired  (w_expired)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Downstream drive: stb is withheld in the cycle a timeout ack is forged
    always_comb begin
        wbm_cyc_o = w_sel_cyc;
        wbm_stb_o = w_sel_stb & ~w_timeout;
        wbm_we_o  = w_sel_we;
        wbm_sel_o = w_sel_sel;
        wbm_dat_o = w_sel_dat;
        wbm_adr_o = w_sel_adr;
    end

    // Response seen by the owner: forged ack on timeout, otherwise the slave's
    always_comb begin
        w_up_ack = 1'b0;
        w_up_dat = '0;
        if (w_granted) begin
            if (w_timeout) begin
                w_up_ack = 1'b1;
                w_up_dat = TIMEOUT_DATA;
            end else begin
                w_up_ack = wbm_ack_i;
                w_up_dat = wbm_dat_i;
            end
        end
    end

    // Route the response to the owner only; the other master sees zeros
    always_comb begin
        wbs_a_ack_o = w_gnt_a ? w_up_ack : 1'b0;
        wbs_a_dat_o = w_gnt_a ? w_up_dat : '0;
        wbs_b_ack_o = w_gnt_b ? w_up_ack : 1'b0;
        wbs_b_dat_o = w_gnt_b ? w_up_dat : '0;
    end

endmodule : wb_arbiter_2way
`default_nettype wire
